chef_status: RTL and testbench

//  Chef-side counterpart to the enemy chase block: generates pepper_stun toward all enemies and consumes their

---
 rtl/chef_status_pkg.sv | 31 +++
 rtl/chef_status_frame_timer.sv | 28 ++
 rtl/chef_status.sv | 135 +++++++++++++
 tb/tb_chef_status.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chef_status_pkg.sv
// Shared types and widths for the chef status block: FSM state, timer/lives/pepper widths
// and the pepper inventory update rule.
package chef_status_pkg;

    localparam int TIMER_W  = 10;
    localparam int LIVES_W  = 3;
    localparam int PEPPER_W = 4;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        RESPAWN   = 2'd2,
        GAME_OVER = 2'd3
    } chef_state_t;

    // A bonus and an accepted throw in the same frame cancel out.
    function automatic logic [PEPPER_W-1:0] pepper_next(
        input logic [PEPPER_W-1:0] cur,
        input logic                add,
        input logic                take,
        input logic [PEPPER_W-1:0] max_val
    );
        if (add && !take)
            return (cur >= max_val) ? max_val : cur + PEPPER_W'(1);
        else if (take && !add)
            return cur - PEPPER_W'(1);
        else
            return cur;
    endfunction

endpackage

// File: rtl/chef_status_frame_timer.sv
// Frame-tick down-counter: load sets the count, clear zeroes it, otherwise it
// decrements while nonzero and rests at zero.
module frame_timer
    import chef_status_pkg::*;
(
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               clear,
    output logic [TIMER_W-1:0] count,
    output logic               nonzero
);

    always_ff @(posedge frame_clk) begin
        if (!Reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - TIMER_W'(1);
    end

    assign nonzero = |count;

endmodule

// File: rtl/chef_status.sv
// Chef pepper inventory, stun, lives and death/respawn sequencing.
// Define PEPPER_REFILL_EN to top the pepper inventory back up to PEPPER_INIT on respawn.
//
// state     | meaning
// ALIVE     | chef playable; throws accepted, enemy touch kills unless invulnerable or stunning
// DYING     | death animation, chef frozen, touches ignored
// RESPAWN   | single frame, chef motion reloads spawn position
// GAME_OVER | no lives left; everything ignored until reset
module chef_status
    import chef_status_pkg::*;
#(
    parameter int PEPPER_INIT   = 5,
    parameter int PEPPER_MAX    = 9,
    parameter int STUN_FRAMES   = 120,
    parameter int LIVES_INIT    = 3,
    parameter int DEATH_FRAMES  = 90,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                frame_clk,
    input  logic                Reset_n,
    input  logic                pepper_key,
    input  logic                enemy_hurt,
    input  logic                bonus_pepper,
    output logic                pepper_stun,
    output logic                chef_freeze,
    output logic                chef_respawn,
    output logic                chef_invuln,
    output logic [LIVES_W-1:0]  lives,
    output logic [PEPPER_W-1:0] pepper_count,
    output logic                game_over
);

    chef_state_t         state;
    logic                key_prev;
    logic                key_rise;
    logic                die;
    logic                throw_ok;
    logic                bonus_ok;
    logic [PEPPER_W-1:0] pep_new;

    logic [TIMER_W-1:0]  stun_count;
    logic [TIMER_W-1:0]  death_count;
    logic [TIMER_W-1:0]  invuln_count;
    logic                death_on;
    logic                unused_bits;

    assign key_rise = pepper_key & ~key_prev;
    assign die      = (state == ALIVE) & enemy_hurt & ~chef_invuln & ~pepper_stun;
    assign throw_ok = (state == ALIVE) & key_rise & ~die & (pepper_count != '0) & ~pepper_stun;
    assign bonus_ok = bonus_pepper & (state != GAME_OVER);

    always_comb begin
        pep_new = pepper_next(pepper_count, bonus_ok, throw_ok, PEPPER_W'(PEPPER_MAX));
`ifdef PEPPER_REFILL_EN
        if (state == RESPAWN && pep_new < PEPPER_W'(PEPPER_INIT))
            pep_new = PEPPER_W'(PEPPER_INIT);
`endif
    end

    frame_timer u_stun_timer (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .load      (throw_ok),
        .load_val  (TIMER_W'(STUN_FRAMES)),
        .clear     (die),
        .count     (stun_count),
        .nonzero   (pepper_stun)
    );

    frame_timer u_death_timer (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .load      (die),
        .load_val  (TIMER_W'(DEATH_FRAMES)),
        .clear     (1'b0),
        .count     (death_count),
        .nonzero   (death_on)
    );

    frame_timer u_invuln_timer (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .load      (state == RESPAWN),
        .load_val  (TIMER_W'(INVULN_FRAMES)),
        .clear     (1'b0),
        .count     (invuln_count),
        .nonzero   (chef_invuln)
    );

    assign unused_bits = ^{stun_count, invuln_count, death_on};

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state        <= ALIVE;
            lives        <= LIVES_W'(LIVES_INIT);
            pepper_count <= PEPPER_W'(PEPPER_INIT);
            key_prev     <= 1'b1;
            chef_freeze  <= 1'b0;
            chef_respawn <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            key_prev <= pepper_key;
            if (state != GAME_OVER)
                pepper_count <= pep_new;
            case (state)
                ALIVE: begin
                    if (die) begin
                        state       <= DYING;
                        chef_freeze <= 1'b1;
                        if (lives != '0)
                            lives <= lives - LIVES_W'(1);
                    end
                end
                DYING: begin
                    if (death_count == TIMER_W'(1)) begin
                        if (lives == '0) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state        <= RESPAWN;
                            chef_respawn <= 1'b1;
                        end
                    end
                end
                RESPAWN: begin
                    state        <= ALIVE;
                    chef_respawn <= 1'b0;
                    chef_freeze  <= 1'b0;
                end
                default: state <= GAME_OVER;
            endcase
        end
    end

endmodule

// File: tb/tb_chef_status.sv
// Bench for chef_status: fixed vector table, directed multi-frame sequences and a
// randomized run against a frame-timeline reference model.
module tb_chef_status;

    localparam int S_FR = 120;
    localparam int D_FR = 90;
    localparam int I_FR = 60;
    localparam int M_ALIVE = 0, M_DYING = 1, M_RESP = 2, M_OVER = 3;

    logic       frame_clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       pepper_key = 1'b0;
    logic       enemy_hurt = 1'b0;
    logic       bonus_pepper = 1'b0;
    logic       pepper_stun, chef_freeze, chef_respawn, chef_invuln, game_over;
    logic [2:0] lives;
    logic [3:0] pepper_count;

    always #5 frame_clk = ~frame_clk;

    chef_status dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .pepper_key   (pepper_key),
        .enemy_hurt   (enemy_hurt),
        .bonus_pepper (bonus_pepper),
        .pepper_stun  (pepper_stun),
        .chef_freeze  (chef_freeze),
        .chef_respawn (chef_respawn),
        .chef_invuln  (chef_invuln),
        .lives        (lives),
        .pepper_count (pepper_count),
        .game_over    (game_over)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        pepper_key = 0; enemy_hurt = 0; bonus_pepper = 0;
        Reset_n = 0; tick();
        Reset_n = 1; tick();
    endtask

    task automatic die_and_wait();
        int n;
        enemy_hurt = 1; tick(); enemy_hurt = 0;
        n = 0;
        while ((chef_freeze || chef_invuln) && !game_over && n < 400) begin
            n++; tick();
        end
    endtask

    // Reference model: absolute frame numbers at which stun/death/invulnerability end.
    int f = 0, stun_end = -1, death_at = -1000, over_from = -1, invuln_end = -1;
    int m_lives = 3, m_pep = 5;
    bit m_kp = 1;

    function automatic int mode_at(input int g);
        if (over_from >= 0 && g >= over_from) return M_OVER;
        if (g >= death_at && g < death_at + D_FR) return M_DYING;
        if (g == death_at + D_FR) return M_RESP;
        return M_ALIVE;
    endfunction

    task automatic model_edge(input bit rst_n, input bit key, input bit hurt, input bit bonus);
        int pre;
        bit stun_on, inv_on, rise, die, acc;
        f++;
        if (!rst_n) begin
            m_lives = 3; m_pep = 5; m_kp = 1;
            stun_end = -1; death_at = -1000; over_from = -1; invuln_end = -1;
            return;
        end
        pre  = mode_at(f - 1);
        rise = key && !m_kp;
        m_kp = key;
        if (pre == M_OVER) return;
        stun_on = (f - 1) < stun_end;
        inv_on  = (f - 1) < invuln_end;
        die = (pre == M_ALIVE) && hurt && !inv_on && !stun_on;
        acc = (pre == M_ALIVE) && !die && rise && m_pep > 0 && !stun_on;
        if (bonus && !acc) m_pep = (m_pep >= 9) ? 9 : m_pep + 1;
        else if (acc && !bonus) m_pep = m_pep - 1;
        if (pre == M_RESP) begin
            invuln_end = f + I_FR;
`ifdef PEPPER_REFILL_EN
            if (m_pep < 5) m_pep = 5;
`endif
        end
        if (die) begin
            m_lives--; stun_end = f; death_at = f;
            if (m_lives == 0) over_from = f + D_FR;
        end
        if (acc) stun_end = f + S_FR;
    endtask

    function automatic logic [11:0] model_out();
        int m;
        logic [2:0] l;
        logic [3:0] p;
        m = mode_at(f);
        l = 3'(m_lives);
        p = 4'(m_pep);
        return {f < stun_end, m != M_ALIVE, m == M_RESP, f < invuln_end, l, p, m == M_OVER};
    endfunction

    typedef struct {
        logic rst_n, key, hurt, bonus;
        int   pep, lv;
        logic stun, frz, go;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int len, n;
        logic [3:0] exp_pep;
        logic [11:0] dut_out;

        vecs[0]  = '{0, 0, 0, 0, 5, 3, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 5, 3, 0, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, 4, 3, 1, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 4, 3, 1, 0, 0};
        vecs[4]  = '{1, 1, 0, 0, 4, 3, 1, 0, 0};
        vecs[5]  = '{1, 0, 0, 1, 5, 3, 1, 0, 0};
        vecs[6]  = '{1, 0, 1, 0, 5, 3, 1, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 5, 3, 0, 0, 0};
        vecs[8]  = '{1, 1, 0, 0, 5, 3, 0, 0, 0};
        vecs[9]  = '{1, 0, 1, 0, 5, 2, 0, 1, 0};
        vecs[10] = '{1, 1, 0, 0, 5, 2, 0, 1, 0};
        vecs[11] = '{1, 0, 0, 1, 6, 2, 0, 1, 0};

        for (int i = 0; i < 12; i++) begin
            Reset_n = vecs[i].rst_n; pepper_key = vecs[i].key;
            enemy_hurt = vecs[i].hurt; bonus_pepper = vecs[i].bonus;
            tick();
            check($sformatf("vec%0d", i),
                  {pepper_count, 1'b0, lives, pepper_stun, chef_freeze, game_over},
                  {4'(vecs[i].pep), 1'b0, 3'(vecs[i].lv), vecs[i].stun, vecs[i].frz, vecs[i].go});
        end

        // single throw: stun length
        do_reset();
        pepper_key = 1; tick(); pepper_key = 0;
        check("throw_count", pepper_count, 4);
        len = 0;
        while (pepper_stun && len < 300) begin len++; tick(); end
        check("stun_len", len, S_FR);

        // held key throws once; press during stun ignored
        do_reset();
        pepper_key = 1; repeat (300) tick();
        pepper_key = 0; tick(); pepper_key = 1; tick(); pepper_key = 0;
        check("held_key_count", pepper_count, 3);
        tick(); pepper_key = 1; tick(); pepper_key = 0;
        check("press_in_stun", pepper_count, 3);

        // death / respawn / invulnerability timing
        do_reset();
        enemy_hurt = 1; tick(); enemy_hurt = 0;
        check("death_lives", lives, 2);
        len = 0;
        while (chef_freeze && !chef_respawn && len < 300) begin len++; tick(); end
        check("dying_len", len, D_FR);
        check("respawn_pulse", {chef_respawn, chef_freeze}, 2'b11);
        tick();
        check("after_respawn", {chef_respawn, chef_freeze, chef_invuln}, 3'b001);
        len = 1;
        enemy_hurt = 1;
        while (chef_invuln && len < 300) begin tick(); if (chef_invuln) len++; end
        enemy_hurt = 0;
        check("invuln_len", len, I_FR);
        check("hurt_in_invuln", {lives, chef_freeze}, {3'd2, 1'b0});

        // game over and escape by reset
        do_reset();
        repeat (3) die_and_wait();
        check("game_over", {game_over, chef_freeze, lives}, {1'b1, 1'b1, 3'd0});
        for (int i = 0; i < 50; i++) begin
            pepper_key = 1'($urandom_range(0, 1));
            bonus_pepper = 1'($urandom_range(0, 1));
            enemy_hurt = 1'($urandom_range(0, 1));
            tick();
        end
        check("game_over_hold", {game_over, pepper_count, lives}, {1'b1, 4'd5, 3'd0});
        do_reset();
        check("reset_from_over", {game_over, chef_freeze, pepper_count, lives}, {1'b0, 1'b0, 4'd5, 3'd3});

        // empty inventory, throw + bonus together
        do_reset();
        repeat (5) begin
            pepper_key = 1; tick(); pepper_key = 0;
            n = 0;
            while (pepper_stun && n < 300) begin n++; tick(); end
        end
        check("drained", pepper_count, 0);
        pepper_key = 1; bonus_pepper = 1; tick(); pepper_key = 0; bonus_pepper = 0;
        check("throw_bonus_at_0", {pepper_count, pepper_stun}, {4'd1, 1'b0});
        die_and_wait();
`ifdef PEPPER_REFILL_EN
        exp_pep = 4'd5;
`else
        exp_pep = 4'd1;
`endif
        check("pepper_after_respawn", pepper_count, exp_pep);

        // saturation
        do_reset();
        bonus_pepper = 1; repeat (10) tick(); bonus_pepper = 0;
        check("bonus_sat", pepper_count, 9);
        pepper_key = 1; bonus_pepper = 1; tick(); pepper_key = 0; bonus_pepper = 0;
        check("throw_bonus_at_max", {pepper_count, pepper_stun}, {4'd9, 1'b1});

        // reset in the middle of dying
        do_reset();
        enemy_hurt = 1; tick(); enemy_hurt = 0;
        repeat (10) tick();
        Reset_n = 0; tick(); Reset_n = 1; tick();
        repeat (100) tick();
        check("reset_mid_dying", {chef_freeze, chef_respawn, chef_invuln, lives},
              {1'b0, 1'b0, 1'b0, 3'd3});

        // randomized run against the model
        pepper_key = 0;
        for (int i = 0; i < 6000 && n_fail < 50; i++) begin
            Reset_n = (i == 0) ? 1'b0 : 1'($urandom_range(0, 699) != 0);
            if ($urandom_range(0, 3) == 0) pepper_key = ~pepper_key;
            enemy_hurt   = 1'($urandom_range(0, 29) == 0);
            bonus_pepper = 1'($urandom_range(0, 11) == 0);
            model_edge(Reset_n, pepper_key, enemy_hurt, bonus_pepper);
            tick();
            dut_out = {pepper_stun, chef_freeze, chef_respawn, chef_invuln,
                       lives, pepper_count, game_over};
            check($sformatf("rand%0d", i), dut_out, model_out());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
